mux_n_hs: RTL and testbench
===========================

# mux_n_hs

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the single-bit 2:1 mux into a flow-controlled channel selector. Selection is either fixed by an external `sel` or round-robin among valid channels. It sits between several producer streams and one consumer, adding one register stage.

## Interface
Parameters:
- `N`, 4: number of input channels, 2..16.
- `W`, 8: data width per channel.
- `SEL_W`, 2: select/channel-index width; must satisfy 2^SEL_W >= N.

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`  input  1  clock; all state changes on rising edge.
- `sys_rst_n`  input  1  asynchronous active-low reset.
- `mode`  input  1  0 = fixed select via `sel`; 1 = round-robin.
- `sel`  input  SEL_W  channel index used when `mode`=0.
- `in_data`  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- `in_valid`  input  N  per-channel valid.
- `in_ready`  output  N  per-channel ready; at most one bit high.
- `out_data`  output  W  registered output data.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  consumer accepts `out_data` when high with `out_valid`.
- `out_ch`  output  SEL_W  index of the channel that `out_data` came from.
- `sel_err`  output  1  registered flag: `mode`=0 and `sel` >= N.

## Operation
- Transfers: an input transfer on channel i occurs when `in_valid[i]` and `in_ready[i]` are both high at a clock edge. An output transfer occurs when `out_valid` and `out_ready` are both high.
- `load_ok` = !`out_valid` | `out_ready`, meaning the output register is free this cycle.
- Grant `g` (combinational):
  - `mode`=0: `g` = `sel` if `sel` < N, else no grant.
  - `mode`=1: `g` = the first channel with `in_valid` high, searching from `rr_ptr`+1 upward and wrapping at N-1 to 0. No grant if no channel is valid.
- `in_ready[i]` = `load_ok` & (i == `g`). No bit is asserted when there is no grant. `in_ready` may depend on `in_valid` only in round-robin mode.
- On an input transfer from `g`:
  - `out_data` <= that channel's word.
  - `out_ch` <= `g`.
  - `out_valid` <= 1.
- On an output transfer with no input transfer in the same cycle, `out_valid` <= 0.
- When output and input transfers coincide, the register reloads in that cycle; `out_valid` stays 1.
- `rr_ptr` (SEL_W bits) <= `g` on every input transfer while `mode`=1. It does not change in `mode`=0.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_ch` are held stable and all `in_ready` bits are 0.
- `sel_err` <= (`mode`==0) & (`sel` >= N), updated every cycle.
- Switching `mode` or `sel` takes effect on the grant in the same cycle. A word already in the output register is unaffected.

## Timing
- Reset values (asynchronous assertion, synchronous-safe release):
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `sel_err`=0.
  - `rr_ptr`=N-1, so channel 0 has first priority.
- Latency: 1 cycle from an input transfer at edge k to `out_valid`/`out_data` visible after edge k.
- Throughput: 1 word/cycle while `out_ready` is held high.
- Reset mid-operation: the word in the output register is dropped and `in_ready` goes to 0 immediately. After release, the first grant uses `rr_ptr`=N-1.
- Round-robin wrap: when `rr_ptr`=N-1, the search starts at 0.
- If only the channel at `rr_ptr` is valid, it is granted again after the full search wraps back to it.
- `sel` >= N: no transfer occurs and `sel_err`=1 one cycle later. Any data already held drains normally.

## Test plan
- Reset and idle: assert `sys_rst_n`=0 mid-stream -> `out_valid`=0, `out_data`=0, `out_ch`=0, `sel_err`=0, `in_ready`=0 at once. After release with all valids high and `mode`=1, the first `out_ch` is 0.
- Fixed select (N=4, W=8): `mode`=0, `sel`=2, channel 2 = 0xA5 valid, `out_ready`=1 -> `in_ready`=4'b0100; next cycle `out_data`=0xA5, `out_ch`=2.
- Backpressure: hold `out_ready`=0 for 5 cycles with word 0x3C held -> `out_data`=0x3C and `out_valid`=1 stable, `in_ready`=0. Raise `out_ready` -> the next word loads on the same edge with no bubble.
- Round-robin, all valid, `out_ready`=1 -> `out_ch` sequence 0,1,2,3,0,1 at 1 word/cycle. Valid only on channels 1 and 3 -> sequence 1,3,1,3.
- Illegal select (N=5, SEL_W=3): `mode`=0, `sel`=6 -> `in_ready`=0 and `sel_err`=1 on the next cycle. Set `sel`=4 -> `sel_err`=0 the cycle after, and channel 4 transfers.
- Mode switch: while in round-robin with `rr_ptr`=1, switch to `mode`=0, `sel`=0 -> only channel 0 is granted and `rr_ptr` stays 1. Return to `mode`=1 -> the next grant is channel 2 if it is valid.

Source files
------------

// File: rtl/mux_n_hs.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes.
// Grant comes from a fixed select or a round-robin search over valid channels.
module mux_n_hs #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_ch,
    output logic             sel_err
);

    localparam int unsigned NU = N;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] g;
    logic             grant_vld;
    logic             load_ok;
    logic             sel_bad;
    logic             g_valid;
    logic [W-1:0]     g_data;
    logic             xfer_in;
    logic [2*N-1:0]   dbl_valid;
    logic [2*N-1:0]   rot_all;
    logic [N-1:0]     rot_valid;
    int unsigned      start;

    assign load_ok   = ~out_valid | out_ready;
    assign sel_bad   = (32'(sel) >= NU);
    assign dbl_valid = {in_valid, in_valid};

    // Rotate the valids so bit 0 is the channel after rr_ptr; the lowest set bit wins.
    always_comb begin
        g         = '0;
        grant_vld = 1'b0;
        start     = (32'(rr_ptr) + 1) % NU;
        rot_all   = dbl_valid >> start;
        rot_valid = rot_all[N-1:0];
        if (!mode) begin
            g         = sel;
            grant_vld = ~sel_bad;
        end else begin
            for (int unsigned j = 0; j < NU; j++) begin
                if (!grant_vld && rot_valid[j]) begin
                    g         = SEL_W'((start + j) % NU);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        g_valid  = 1'b0;
        g_data   = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (g == SEL_W'(i)) begin
                g_valid     = in_valid[i];
                g_data      = in_data[i*W +: W];
                in_ready[i] = sys_rst_n & load_ok & grant_vld;
            end
        end
    end

    assign xfer_in = sys_rst_n & grant_vld & load_ok & g_valid;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= SEL_W'(N - 1);
        end else begin
            sel_err <= ~mode & sel_bad;
            if (xfer_in) begin
                out_data  <= g_data;
                out_ch    <= g;
                out_valid <= 1'b1;
                if (mode) begin
                    rr_ptr <= g;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_hs.sv
// Bench for mux_n_hs: table-driven handshake vectors with a word scoreboard,
// plus hand sequences for reset mid-stream and out-of-range select.
module tb_mux_n_hs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic        sel_err;

    logic        m5;
    logic [2:0]  sel5;
    logic [39:0] d5;
    logic [4:0]  v5;
    logic [4:0]  r5;
    logic [7:0]  od5;
    logic        ov5;
    logic        ordy5;
    logic [2:0]  och5;
    logic        serr5;

    mux_n_hs #(.N(4), .W(8), .SEL_W(2)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .sel_err(sel_err)
    );

    mux_n_hs #(.N(5), .W(8), .SEL_W(3)) u_dut5 (
        .sys_clk(clk), .sys_rst_n(rst_n), .mode(m5), .sel(sel5),
        .in_data(d5), .in_valid(v5), .in_ready(r5),
        .out_data(od5), .out_valid(ov5), .out_ready(ordy5),
        .out_ch(och5), .sel_err(serr5)
    );

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] rdy;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic ordy, input logic [3:0] rdy);
        vec_t r;
        r.m = m; r.s = s; r.v = v; r.ordy = ordy; r.rdy = rdy;
        tbl.push_back(r);
    endtask

    task automatic run_row(input int idx, input vec_t r);
        exp_t e;
        @(negedge clk);
        mode      = r.m;
        sel       = r.s;
        in_valid  = r.v;
        out_ready = r.ordy;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'($urandom);
        if (idx == 0) in_data[23:16] = 8'hA5;
        if (idx == 2) in_data[15:8]  = 8'h3C;
        #1;
        chk($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(r.rdy));
        chk($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'(q.size() != 0));
        chk($sformatf("sel_err[%0d]", idx), 64'(sel_err), 64'(0));
        if (q.size() != 0) begin
            chk($sformatf("out_data[%0d]", idx), 64'(out_data), 64'(q[0].data));
            chk($sformatf("out_ch[%0d]", idx), 64'(out_ch), 64'(q[0].ch));
            if (r.ordy) void'(q.pop_front());
        end
        if ((r.rdy & r.v) != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (r.rdy[i]) begin
                    e.ch   = 2'(i);
                    e.data = in_data[i*8 +: 8];
                end
            end
            q.push_back(e);
        end
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1; in_data = '0;
        m5 = 1'b0; sel5 = '0; v5 = '0; ordy5 = 1'b1; d5 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_ch", 64'(out_ch), 64'(0));
        chk("rst_sel_err", 64'(sel_err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        in_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // fixed select on channel 2
        add(0, 2, 4'b0100, 1, 4'b0100);
        add(0, 2, 4'b0000, 1, 4'b0100);
        // backpressure for 5 cycles, then reload without a bubble
        add(0, 1, 4'b0010, 0, 4'b0010);
        for (int k = 0; k < 5; k++) add(0, 1, 4'b0010, 0, 4'b0000);
        add(0, 1, 4'b0010, 1, 4'b0010);
        // round-robin, all valid: 0,1,2,3,0,1
        add(1, 0, 4'b1111, 1, 4'b0001);
        add(1, 0, 4'b1111, 1, 4'b0010);
        add(1, 0, 4'b1111, 1, 4'b0100);
        add(1, 0, 4'b1111, 1, 4'b1000);
        add(1, 0, 4'b1111, 1, 4'b0001);
        add(1, 0, 4'b1111, 1, 4'b0010);
        // fixed select leaves rr_ptr=1; back in round-robin channel 2 is next
        add(0, 0, 4'b1111, 1, 4'b0001);
        add(0, 0, 4'b1111, 1, 4'b0001);
        add(1, 0, 4'b1111, 1, 4'b0100);
        // only channels 1 and 3 valid: 3,1,3,1 (rr_ptr was 2)
        add(1, 0, 4'b1010, 1, 4'b1000);
        add(1, 0, 4'b1010, 1, 4'b0010);
        add(1, 0, 4'b1010, 1, 4'b1000);
        add(1, 0, 4'b1010, 1, 4'b0010);
        // only the channel at rr_ptr is valid: granted again after wrap
        add(1, 0, 4'b0010, 1, 4'b0010);
        add(1, 0, 4'b0000, 1, 4'b0000);
        add(1, 0, 4'b0000, 1, 4'b0000);
        // round-robin under backpressure
        add(1, 0, 4'b0001, 0, 4'b0001);
        add(1, 0, 4'b0001, 0, 4'b0000);
        add(1, 0, 4'b0000, 1, 4'b0000);
        add(1, 0, 4'b0000, 1, 4'b0000);

        foreach (tbl[i]) run_row(i, tbl[i]);

        // reset mid-stream drops the held word and blocks inputs at once
        @(negedge clk);
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'($urandom);
        @(negedge clk);
        #1;
        chk("held_before_rst", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_out_ch", 64'(out_ch), 64'(0));
        chk("mid_rst_sel_err", 64'(sel_err), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        d = in_data[7:0];
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        chk("post_rst_out_ch", 64'(out_ch), 64'(0));
        chk("post_rst_out_data", 64'(out_data), 64'(d));
        chk("post_rst_out_valid", 64'(out_valid), 64'(1));
        @(negedge clk);
        in_valid = 4'h0;
        q.delete();

        // out-of-range select on the 5-channel instance
        m5 = 1'b0; sel5 = 3'd6; v5 = 5'h1F; ordy5 = 1'b1;
        for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'($urandom);
        #1;
        chk("sel6_in_ready", 64'(r5), 64'(0));
        @(negedge clk);
        #1;
        chk("sel6_sel_err", 64'(serr5), 64'(1));
        chk("sel6_out_valid", 64'(ov5), 64'(0));
        chk("sel6_in_ready2", 64'(r5), 64'(0));
        sel5 = 3'd4;
        d = d5[39:32];
        #1;
        chk("sel4_in_ready", 64'(r5), 64'(5'b10000));
        chk("sel4_sel_err_prev", 64'(serr5), 64'(1));
        @(posedge clk);
        #1;
        chk("sel4_sel_err", 64'(serr5), 64'(0));
        chk("sel4_out_valid", 64'(ov5), 64'(1));
        chk("sel4_out_ch", 64'(och5), 64'(4));
        chk("sel4_out_data", 64'(od5), 64'(d));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
